// File: rtl/dp_ram_rw_ind_if.sv
// dp_ram_rw_ind_if: write/read bus of the simple dual-port RAM.
// Signals:
//   WrEn_SI    write enable
//   WrAddr_DI  write address (ADDR_WIDTH)
//   WrData_DI  write data (DATA_WIDTH)
//   RdAddr_DI  read address (ADDR_WIDTH), always enabled
//   RdData_DO  read data (DATA_WIDTH)
// Modports: master = RAM user, slave = RAM.
interface dp_ram_rw_ind_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  WrEn_SI;
    logic [ADDR_WIDTH-1:0] WrAddr_DI;
    logic [DATA_WIDTH-1:0] WrData_DI;
    logic [ADDR_WIDTH-1:0] RdAddr_DI;
    logic [DATA_WIDTH-1:0] RdData_DO;

    modport master (
        output WrEn_SI,
        output WrAddr_DI,
        output WrData_DI,
        output RdAddr_DI,
        input  RdData_DO
    );

    modport slave (
        input  WrEn_SI,
        input  WrAddr_DI,
        input  WrData_DI,
        input  RdAddr_DI,
        output RdData_DO
    );
endinterface

// File: rtl/dp_ram_rw_ind.sv
// dp_ram_rw_ind: simple dual-port RAM, one write port and one read port with
// independent addresses on a single clock.
// SYNC_READ=1 gives a registered read (1-cycle latency, block-RAM style);
// SYNC_READ=0 gives a combinational read (distributed-RAM style).
// Out-of-range writes are dropped; out-of-range reads return zero.
// Optional macro DP_RAM_RST_CLEAR_EN: reset also clears every memory word.
// Ports:
//   Clk_CI   clock, rising edge
//   Rst_RBI  asynchronous active-low reset
//   ram_if   dp_ram_rw_ind_if.slave (WrEn_SI, WrAddr_DI, WrData_DI,
//            RdAddr_DI, RdData_DO)
module dp_ram_rw_ind #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_DEPTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SYNC_READ  = 1
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,
    dp_ram_rw_ind_if.slave   ram_if
);
    localparam int unsigned IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    logic             wr_hit_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic             rd_hit_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    // Address decode; the extra MSB keeps the range check exact when
    // DATA_DEPTH equals 2**ADDR_WIDTH.
    always_comb begin
        wr_hit_c = ram_if.WrEn_SI && ({1'b0, ram_if.WrAddr_DI} < DEPTH_C);
        wr_idx_c = IDX_W'(ram_if.WrAddr_DI);
        rd_hit_c = ({1'b0, ram_if.RdAddr_DI} < DEPTH_C);
        rd_idx_c = IDX_W'(ram_if.RdAddr_DI);
    end

    // Array write. Reset is in the sensitivity list so an edge seen while
    // reset is low never writes; the array itself is only cleared on request.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
`ifdef DP_RAM_RST_CLEAR_EN
            for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`else
`endif
        end else if (wr_hit_c) begin
            mem_q[wr_idx_c] <= ram_if.WrData_DI;
        end
    end

    // Array read with zero for out-of-range addresses.
    always_comb begin
        rd_word_c = '0;
        if (rd_hit_c) begin
            rd_word_c = mem_q[rd_idx_c];
        end
    end

    generate
        if (SYNC_READ != 0) begin : g_sync_rd
            logic [DATA_WIDTH-1:0] rd_data_d;
            logic [DATA_WIDTH-1:0] rd_data_q;

            // Captures the pre-write contents on a same-address collision.
            always_comb begin
                rd_data_d = rd_word_c;
            end

            always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
                if (!Rst_RBI) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end

            assign ram_if.RdData_DO = rd_data_q;
        end else begin : g_async_rd
            assign ram_if.RdData_DO = rd_word_c;
        end
    endgenerate
endmodule

// File: tb/tb_dp_ram_rw_ind.sv
// tb_dp_ram_rw_ind: directed test of dp_ram_rw_ind in registered-read mode
// (depth 8 and depth 6) and combinational-read mode (depth 8).
module tb_dp_ram_rw_ind;
    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    dp_ram_rw_ind_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) s_if ();
    dp_ram_rw_ind_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) a_if ();
    dp_ram_rw_ind_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) d_if ();

    dp_ram_rw_ind #(.ADDR_WIDTH(3), .DATA_DEPTH(8), .DATA_WIDTH(32), .SYNC_READ(1)) u_sync (
        .Clk_CI  (clk),
        .Rst_RBI (rst_n),
        .ram_if  (s_if.slave)
    );

    dp_ram_rw_ind #(.ADDR_WIDTH(3), .DATA_DEPTH(8), .DATA_WIDTH(32), .SYNC_READ(0)) u_async (
        .Clk_CI  (clk),
        .Rst_RBI (rst_n),
        .ram_if  (a_if.slave)
    );

    dp_ram_rw_ind #(.ADDR_WIDTH(3), .DATA_DEPTH(6), .DATA_WIDTH(32), .SYNC_READ(1)) u_d6 (
        .Clk_CI  (clk),
        .Rst_RBI (rst_n),
        .ram_if  (d_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        s_if.WrEn_SI = 1'b0; s_if.WrAddr_DI = '0; s_if.WrData_DI = '0; s_if.RdAddr_DI = '0;
        a_if.WrEn_SI = 1'b0; a_if.WrAddr_DI = '0; a_if.WrData_DI = '0; a_if.RdAddr_DI = '0;
        d_if.WrEn_SI = 1'b0; d_if.WrAddr_DI = '0; d_if.WrData_DI = '0; d_if.RdAddr_DI = '0;

        // Reset state of the registered outputs
        #2;
        chk("rst_sync", s_if.RdData_DO, 32'h0);
        chk("rst_d6", d_if.RdData_DO, 32'h0);
        tick();
        tick();
        chk("rst_held_sync", s_if.RdData_DO, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_released_sync", s_if.RdData_DO, 32'h0);

        // Registered read: one-cycle latency
        s_if.WrEn_SI = 1'b1; s_if.WrAddr_DI = 3'd2; s_if.WrData_DI = 32'hDEADBEEF;
        tick();
        s_if.WrAddr_DI = 3'd3; s_if.WrData_DI = 32'h0000_1234;
        tick();
        s_if.WrEn_SI = 1'b0;
        s_if.RdAddr_DI = 3'd3;
        tick();
        chk("sync_rd3", s_if.RdData_DO, 32'h0000_1234);
        s_if.RdAddr_DI = 3'd2;
        #1;
        chk("sync_latency_hold", s_if.RdData_DO, 32'h0000_1234);
        tick();
        chk("sync_rd2", s_if.RdData_DO, 32'hDEADBEEF);

        // Registered read-during-write returns old data, then new data
        s_if.WrEn_SI = 1'b1; s_if.WrAddr_DI = 3'd5; s_if.WrData_DI = 32'h11;
        tick();
        s_if.WrData_DI = 32'h22; s_if.RdAddr_DI = 3'd5;
        tick();
        chk("sync_rdw_old", s_if.RdData_DO, 32'h11);
        s_if.WrEn_SI = 1'b0;
        tick();
        chk("sync_rdw_new", s_if.RdData_DO, 32'h22);

        // Combinational read: address change visible without an edge
        a_if.WrEn_SI = 1'b1; a_if.WrAddr_DI = 3'd0; a_if.WrData_DI = 32'h0;
        tick();
        a_if.WrAddr_DI = 3'd7; a_if.WrData_DI = 32'hA5A5A5A5;
        tick();
        a_if.WrEn_SI = 1'b0;
        a_if.RdAddr_DI = 3'd0;
        #1;
        chk("async_rd0", a_if.RdData_DO, 32'h0);
        a_if.RdAddr_DI = 3'd7;
        #1;
        chk("async_rd7", a_if.RdData_DO, 32'hA5A5A5A5);

        // Combinational read-during-write: old before edge, new after
        a_if.WrEn_SI = 1'b1; a_if.WrAddr_DI = 3'd4; a_if.WrData_DI = 32'h44;
        tick();
        a_if.WrData_DI = 32'h55; a_if.RdAddr_DI = 3'd4;
        #1;
        chk("async_rdw_old", a_if.RdData_DO, 32'h44);
        tick();
        chk("async_rdw_new", a_if.RdData_DO, 32'h55);
        a_if.WrEn_SI = 1'b0;

        // Fill both depth-8 RAMs with addr*3, then stream reads
        for (int i = 0; i < 8; i++) begin
            s_if.WrEn_SI = 1'b1; s_if.WrAddr_DI = 3'(i); s_if.WrData_DI = 32'(i * 3);
            a_if.WrEn_SI = 1'b1; a_if.WrAddr_DI = 3'(i); a_if.WrData_DI = 32'(i * 3);
            tick();
        end
        s_if.WrEn_SI = 1'b0;
        a_if.WrEn_SI = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_if.RdAddr_DI = 3'(i);
            a_if.RdAddr_DI = 3'(i);
            #1;
            chk($sformatf("async_stream%0d", i), a_if.RdData_DO, 32'(i * 3));
            tick();
            chk($sformatf("sync_stream%0d", i), s_if.RdData_DO, 32'(i * 3));
        end

        // Non-power-of-two depth: out-of-range writes dropped, reads zero
        for (int i = 0; i < 6; i++) begin
            d_if.WrEn_SI = 1'b1; d_if.WrAddr_DI = 3'(i); d_if.WrData_DI = 32'(32'h100 + i);
            tick();
        end
        d_if.WrAddr_DI = 3'd6; d_if.WrData_DI = 32'hFF;
        tick();
        d_if.WrAddr_DI = 3'd7;
        tick();
        d_if.WrEn_SI = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d_if.RdAddr_DI = 3'(i);
            tick();
            chk($sformatf("d6_rd%0d", i), d_if.RdData_DO, 32'(32'h100 + i));
        end
        d_if.RdAddr_DI = 3'd6;
        tick();
        chk("d6_oor6", d_if.RdData_DO, 32'h0);
        d_if.RdAddr_DI = 3'd7;
        tick();
        chk("d6_oor7", d_if.RdData_DO, 32'h0);

        // Reset mid-stream with a write pending
        s_if.RdAddr_DI = 3'd2;
        tick();
        chk("pre_rst_rd2", s_if.RdData_DO, 32'd6);
        s_if.WrEn_SI = 1'b1; s_if.WrAddr_DI = 3'd1; s_if.WrData_DI = 32'h0BAD;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_clear", s_if.RdData_DO, 32'h0);
        tick();
        chk("rst_mid_held", s_if.RdData_DO, 32'h0);
        rst_n = 1'b1;
        s_if.WrEn_SI = 1'b0;
        s_if.RdAddr_DI = 3'd1;
        #1;
        chk("rst_mid_release", s_if.RdData_DO, 32'h0);
        tick();
`ifdef DP_RAM_RST_CLEAR_EN
        chk("post_rst_rd1", s_if.RdData_DO, 32'h0);
        for (int i = 0; i < 8; i++) begin
            s_if.RdAddr_DI = 3'(i);
            a_if.RdAddr_DI = 3'(i);
            #1;
            chk($sformatf("clr_async%0d", i), a_if.RdData_DO, 32'h0);
            tick();
            chk($sformatf("clr_sync%0d", i), s_if.RdData_DO, 32'h0);
        end
`else
        chk("post_rst_rd1", s_if.RdData_DO, 32'd3);
        a_if.RdAddr_DI = 3'd5;
        #1;
        chk("post_rst_async_kept", a_if.RdData_DO, 32'd15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
